dmem_arbiter: RTL
=================

# dmem_arbiter

Two-requester round-robin arbiter and sequencer for the single-port data memory. It accepts load/store requests from the core LSU (port 0) and the debug/loader port (port 1), and serialises them onto the memory's `addr`/`write_data_in`/`mem_read_en`/`mem_write_en` interface. It bounds-checks word addresses and returns a registered read-data/error response to the winning requester. It sits between the requesters and the data memory; the data memory itself is unchanged.

## Interface
- `DEPTH_WORDS`, 28: number of valid 32-bit words; word index = `addr[31:2]`.
- `ADDR_W`, 32: request byte-address width.
- `DATA_W`, 32: data width.

Ports, with `i` in {0,1}:
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req{i}_valid`  in  1: request pending.
- `req{i}_ready`  out  1: request accepted this cycle.
- `req{i}_we`  in  1: 1 = store, 0 = load.
- `req{i}_addr`  in  ADDR_W: byte address; bits [1:0] are ignored.
- `req{i}_wdata`  in  DATA_W: store data.
- `rsp{i}_valid`  out  1: one-cycle response pulse.
- `rsp{i}_rdata`  out  DATA_W: load data; 0 for stores and errors.
- `rsp{i}_err`  out  1: address out of bounds.
- `mem_addr`  out  ADDR_W: to memory `addr`.
- `mem_wdata`  out  DATA_W: to memory `write_data_in`.
- `mem_read_en`  out  1: to memory read enable.
- `mem_write_en`  out  1: to memory write enable.
- `mem_rdata`  in  DATA_W: from memory `read_data_out`; combinational, valid in the same cycle as `mem_read_en`.

## Operation
- FSM has two states, IDLE and ACCESS.
- **IDLE**
  - If any `req{i}_valid` is high, pick a winner, assert its `req{i}_ready` (combinational, in the same cycle), latch `we`/`addr`/`wdata`/requester id into holding registers, and go to ACCESS.
  - If no request is valid, stay in IDLE.
- **ACCESS**
  - Drive `mem_addr`/`mem_wdata` from the holding registers.
  - In bounds (`addr[31:2] < DEPTH_WORDS`):
    - Store: assert `mem_write_en`. The memory commits on the closing edge.
    - Load: assert `mem_read_en`, and capture `mem_rdata` on the closing edge.
  - Out of bounds: both enables stay 0 and `err` is latched.
  - Always return to IDLE on the next edge.
- **Response**
  - `rsp{id}_valid` is high for exactly the cycle after ACCESS, with `rdata`/`err` registered.
  - The other port's `rsp` stays 0.
- **Arbitration**
  - One requester valid: that requester wins.
  - Both valid: the winner is the requester not granted last (`last_grant` register).
  - `last_grant` updates only on a grant.
- `req{i}_ready` is never asserted outside IDLE. A requester holds `valid`/payload stable until it sees `ready`.
- `mem_addr`/`mem_wdata` are 0 whenever the state is not ACCESS. Both memory enables are never high together.

## Timing
- Accept at edge k; ACCESS is the cycle between edges k and k+1; `rsp_valid` is high during cycle k+1 to k+2.
- Throughput: one transaction per 2 cycles. A new accept can happen in the same cycle as the previous response pulse.
- Reset (`reset_n` low, asynchronous):
  - State goes to IDLE and `last_grant` to 1, so port 0 wins the first conflict.
  - All `ready`, `rsp*`, `mem_*` outputs go to 0 immediately.
  - Reset during ACCESS aborts the transaction: `mem_write_en` drops at once, and no response is issued.
- Release: the first accept is possible on the first rising edge with `reset_n` high.
- Simultaneous valid on both ports while IDLE: exactly one `ready` is asserted. The loser keeps `valid` and is granted at its next IDLE cycle if the winner does not re-request. If the winner does re-request, the loser still wins, by round-robin.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_ACCESS`);
  - the requester-id type (1 bit);
  - the default `DEPTH_WORDS` localparam;
  - the response struct (`valid`, `rdata`, `err`).
- Sub-module `dmem_rr_pick2` is a combinational 2-way round-robin picker.
  - Inputs: `valid[1:0]`, `last_grant`.
  - Outputs: `grant[1:0]` (one-hot or zero) and `winner_id`.
- The top level contains the FSM, holding registers, bounds check, and response registers.

## Test plan
- Reset then single load: mem word 3 = 0x0000_00AB; port 0 loads addr 0x0C at edge k → `req0_ready` in the accept cycle, `mem_read_en`=1 in cycle k, `rsp0_valid`=1 with `rdata`=0xAB in cycle k+1, `err`=0.
- Store then load: port 1 stores 0xDEAD_0001 to addr 0x10, then loads addr 0x10 → `mem_write_en` for exactly one cycle; the load returns 0xDEAD_0001.
- Conflict: both ports request continuously after reset → grants alternate 0,1,0,1; each response arrives 2 cycles after its accept.
- Out of bounds: port 0 stores to addr 0x70 (word 28) → no `mem_write_en`; `rsp0_err`=1 and `rdata`=0. A load from 0x6C (word 27) gives `err`=0.
- Reset mid-access: drop `reset_n` during the ACCESS cycle of a store → `mem_write_en` is 0 at once, the target word is unchanged, and no `rsp` follows.
- Idle hygiene: no requests for 10 cycles → all `mem_*` and `rsp*` stay 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
//   arb_state_e : arbiter FSM state encoding
//   req_id_t    : requester id (0 = core LSU, 1 = debug/loader)
//   rsp_t       : registered response (valid, rdata, err)
package dmem_arb_pkg;

  localparam int DEF_DEPTH_WORDS = 28;
  localparam int DEF_DATA_W      = 32;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_e;

  typedef logic req_id_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_DATA_W-1:0] rdata;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/dmem_rr_pick2.sv
// Combinational two-way round-robin picker.
//   valid      : pending requests, one bit per requester
//   last_grant : requester granted most recently
//   grant      : one-hot grant, or zero when nothing is pending
//   winner_id  : index of the granted requester (meaningful only when grant != 0)
module dmem_rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last_grant,
  output logic [1:0] grant,
  output req_id_t    winner_id
);

  always_comb begin
    // Port 1 wins when it is alone, or when both are pending and port 0 went last.
    winner_id = valid[1] & (~valid[0] | (last_grant == 1'b0));
    grant     = 2'b00;
    if (valid != 2'b00) begin
      grant = winner_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer in front of the single-port data memory.
// Port 0 is the core LSU, port 1 the debug/loader. Each transaction takes one
// IDLE (accept) cycle and one ACCESS cycle; the response pulse follows ACCESS.
//   req{0,1}_*  : request handshake (valid/ready) with we/addr/wdata payload
//   rsp{0,1}_*  : one-cycle response pulse with rdata/err
//   mem_*       : memory addr/wdata/enables, mem_rdata is combinational
//
// state      | meaning
// ARB_IDLE   | waiting; grants a requester combinationally and latches payload
// ARB_ACCESS | drives the memory from the holding registers for one cycle
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read_en,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q;
  req_id_t           last_grant_q;
  req_id_t           hold_id_q;
  logic              hold_we_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [DATA_W-1:0] hold_wdata_q;
  rsp_t [1:0]        rsp_q;
  rsp_t              rsp_d;

  logic [1:0] req_valid;
  logic [1:0] grant;
  req_id_t    winner_id;
  logic       idle;
  logic       access;
  logic       in_bounds;

  assign req_valid = {req1_valid, req0_valid};

  dmem_rr_pick2 u_pick (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .winner_id  (winner_id)
  );

  assign idle   = (state_q == ARB_IDLE);
  assign access = (state_q == ARB_ACCESS);

  // ready is combinational from the inputs, so it is also gated by reset_n to
  // stay low while reset is held.
  assign req0_ready = idle & grant[0] & reset_n;
  assign req1_ready = idle & grant[1] & reset_n;

  assign in_bounds = hold_addr_q[ADDR_W-1:2] < (ADDR_W-2)'(DEPTH_WORDS);

  assign mem_addr     = access ? hold_addr_q  : '0;
  assign mem_wdata    = access ? hold_wdata_q : '0;
  assign mem_write_en = access &  hold_we_q & in_bounds;
  assign mem_read_en  = access & ~hold_we_q & in_bounds;

  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = 1'b1;
    rsp_d.err   = ~in_bounds;
    if (in_bounds && !hold_we_q) begin
      rsp_d.rdata = DEF_DATA_W'(mem_rdata);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
      hold_id_q    <= 1'b0;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      rsp_q        <= '0;
    end else begin
      rsp_q <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (|req_valid) begin
            state_q      <= ARB_ACCESS;
            last_grant_q <= winner_id;
            hold_id_q    <= winner_id;
            hold_we_q    <= winner_id ? req1_we    : req0_we;
            hold_addr_q  <= winner_id ? req1_addr  : req0_addr;
            hold_wdata_q <= winner_id ? req1_wdata : req0_wdata;
          end
        end
        ARB_ACCESS: begin
          state_q          <= ARB_IDLE;
          rsp_q[hold_id_q] <= rsp_d;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign rsp0_valid = rsp_q[0].valid;
  assign rsp0_rdata = DATA_W'(rsp_q[0].rdata);
  assign rsp0_err   = rsp_q[0].err;
  assign rsp1_valid = rsp_q[1].valid;
  assign rsp1_rdata = DATA_W'(rsp_q[1].rdata);
  assign rsp1_err   = rsp_q[1].err;

endmodule
